alu_logic_seq: RTL and testbench



---
 rtl/vect_pkg.sv | 28 ++
 rtl/alu_logic_seq_fifo.sv | 42 ++++
 rtl/alu_logic_seq.sv | 155 +++++++++++++++
 tb/tb_alu_logic_seq.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vect_pkg.sv
// Shared vector-unit types and constants: sequencer states, logic-group index,
// logic-unit opcode width and logic-class opcode decode.
package vect_pkg;

  localparam int unsigned LU_OCODE_W = 7;
  localparam int unsigned LGRP_W     = 8;

  typedef logic [LGRP_W-1:0] lgrp_idx_t;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RUN  = 1'b1
  } seq_state_t;

  localparam logic [5:0] FUNCT6_VAND = 6'b001001;
  localparam logic [5:0] FUNCT6_VOR  = 6'b001010;
  localparam logic [5:0] FUNCT6_VXOR = 6'b001011;
  localparam logic       CAT_INT     = 1'b0;

  // Opcode layout is {funct6, category}; only integer-category bitwise ops qualify.
  function automatic logic is_logic_op(input logic [LU_OCODE_W-1:0] ocode);
    logic [5:0] funct6;
    funct6 = ocode[LU_OCODE_W-1:1];
    return (ocode[0] == CAT_INT) &&
           ((funct6 == FUNCT6_VAND) || (funct6 == FUNCT6_VOR) || (funct6 == FUNCT6_VXOR));
  endfunction

endpackage

// File: rtl/alu_logic_seq_fifo.sv
// Two-entry result buffer holding {group index, result data} between the
// logic unit and the VRF write port.
module alu_res_fifo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic [1:0]       count,
  output logic             empty
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(push) - 2'(pop);
    end
  end

  assign head_data = mem[rd_ptr];
  assign empty     = (count == 2'd0);

endmodule

// File: rtl/alu_logic_seq.sv
// Element-group sequencer: reads source groups from the VRF, feeds the
// combinational logic unit, buffers results and writes them back tail-masked.
module alu_logic_seq
  import vect_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned LANES      = 4,
  parameter int unsigned VL_WIDTH   = 8,
  parameter int unsigned REG_AW     = 5
) (
  input  logic                        module_clk_i,
  input  logic                        rst_i,
  input  logic                        op_valid_i,
  output logic                        op_ready_o,
  input  logic [LU_OCODE_W-1:0]       op_ocode_i,
  input  logic [VL_WIDTH-1:0]         op_vl_i,
  input  logic [REG_AW-1:0]           op_vs1_i,
  input  logic [REG_AW-1:0]           op_vs2_i,
  input  logic [REG_AW-1:0]           op_vd_i,
  output logic                        rd_en_o,
  output logic [REG_AW-1:0]           rd_addr1_o,
  output logic [REG_AW-1:0]           rd_addr2_o,
  output logic [VL_WIDTH-1:0]         rd_grp_o,
  input  logic [LANES*DATA_WIDTH-1:0] rd_data1_i,
  input  logic [LANES*DATA_WIDTH-1:0] rd_data2_i,
  output logic                        lu_e_o,
  output logic [LU_OCODE_W-1:0]       lu_ocode_o,
  output logic [LANES*DATA_WIDTH-1:0] lu_a_o,
  output logic [LANES*DATA_WIDTH-1:0] lu_b_o,
  input  logic [LANES*DATA_WIDTH-1:0] lu_result_i,
  output logic                        wr_en_o,
  input  logic                        wr_ready_i,
  output logic [REG_AW-1:0]           wr_addr_o,
  output logic [VL_WIDTH-1:0]         wr_grp_o,
  output logic [LANES-1:0]            wr_lane_en_o,
  output logic [LANES*DATA_WIDTH-1:0] wr_data_o,
  output logic                        busy_o,
  output logic                        done_o
);

  localparam int unsigned DW = LANES * DATA_WIDTH;
  localparam int unsigned FW = VL_WIDTH + DW;
  localparam int unsigned EW = VL_WIDTH + 8;

  seq_state_t state, state_nxt;

  logic [LU_OCODE_W-1:0] ocode_q;
  logic [VL_WIDTH-1:0]   vl_q, ng_q, issue_cnt, wr_cnt, inflight_grp;
  logic [REG_AW-1:0]     vs1_q, vs2_q, vd_q;
  logic                  inflight, done_q;
  logic                  accept, pop, last_pop, run;
  logic [2:0]            occ;
  logic [FW-1:0]         fifo_head;
  logic [1:0]            fifo_count;
  logic                  fifo_empty;

  assign run      = (state == SEQ_RUN);
  assign accept   = op_valid_i && (state == SEQ_IDLE);
  assign pop      = wr_en_o && wr_ready_i;
  assign last_pop = run && pop && ((wr_cnt + VL_WIDTH'(1)) == ng_q);

  always_ff @(posedge module_clk_i or posedge rst_i) begin
    if (rst_i) state <= SEQ_IDLE;
    else       state <= state_nxt;
  end

  // A zero-length op completes in the accept edge itself, so it never enters RUN.
  always_comb begin
    state_nxt = state;
    case (state)
      SEQ_IDLE: if (accept && (op_vl_i != '0)) state_nxt = SEQ_RUN;
      SEQ_RUN:  if (last_pop)                  state_nxt = SEQ_IDLE;
      default:                                 state_nxt = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge module_clk_i or posedge rst_i) begin
    if (rst_i) begin
      ocode_q      <= '0;
      vl_q         <= '0;
      ng_q         <= '0;
      vs1_q        <= '0;
      vs2_q        <= '0;
      vd_q         <= '0;
      issue_cnt    <= '0;
      wr_cnt       <= '0;
      inflight     <= 1'b0;
      inflight_grp <= '0;
      done_q       <= 1'b0;
    end else begin
      inflight <= rd_en_o;
      done_q   <= last_pop || (accept && (op_vl_i == '0));
      if (accept) begin
        ocode_q   <= op_ocode_i;
        vl_q      <= op_vl_i;
        ng_q      <= VL_WIDTH'((EW'(op_vl_i) + EW'(LANES - 1)) / EW'(LANES));
        vs1_q     <= op_vs1_i;
        vs2_q     <= op_vs2_i;
        vd_q      <= op_vd_i;
        issue_cnt <= '0;
        wr_cnt    <= '0;
      end else begin
        if (rd_en_o) begin
          issue_cnt    <= issue_cnt + VL_WIDTH'(1);
          inflight_grp <= issue_cnt;
        end
        if (pop) wr_cnt <= wr_cnt + VL_WIDTH'(1);
      end
    end
  end

  // Occupancy counts the group in flight, buffered results, and the one about to issue.
  assign occ     = 3'(inflight) + 3'(fifo_count) - 3'(pop) + 3'd1;
  assign rd_en_o = run && (issue_cnt < ng_q) && (occ <= 3'd2);

  assign rd_addr1_o = vs1_q;
  assign rd_addr2_o = vs2_q;
  assign rd_grp_o   = issue_cnt;

  assign lu_e_o     = inflight;
  assign lu_ocode_o = run ? ocode_q : '0;
  assign lu_a_o     = inflight ? rd_data1_i : '0;
  assign lu_b_o     = inflight ? rd_data2_i : '0;

  alu_res_fifo #(
    .WIDTH(FW)
  ) u_res_fifo (
    .clk      (module_clk_i),
    .rst      (rst_i),
    .push     (inflight),
    .pop      (pop),
    .push_data({inflight_grp, lu_result_i}),
    .head_data(fifo_head),
    .count    (fifo_count),
    .empty    (fifo_empty)
  );

  assign wr_en_o   = !fifo_empty;
  assign wr_addr_o = vd_q;
  assign wr_grp_o  = wr_en_o ? fifo_head[FW-1:DW] : '0;
  assign wr_data_o = wr_en_o ? fifo_head[DW-1:0]  : '0;

  always_comb begin
    wr_lane_en_o = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      wr_lane_en_o[i] = wr_en_o &&
        ((EW'(wr_grp_o) * EW'(LANES) + EW'(i)) < EW'(vl_q));
    end
  end

  assign op_ready_o = (state == SEQ_IDLE);
  assign busy_o     = run;
  assign done_o     = done_q;

endmodule

// File: tb/tb_alu_logic_seq.sv
// Scoreboard bench for alu_logic_seq with a VRF read model and a bitwise-AND
// logic unit; cycle traces check issue/write/done timing.
module tb_alu_logic_seq;

  logic         clk = 1'b0;
  logic         rst;
  logic         op_valid, op_ready;
  logic [6:0]   op_ocode;
  logic [7:0]   op_vl;
  logic [4:0]   op_vs1, op_vs2, op_vd;
  logic         rd_en;
  logic [4:0]   rd_addr1, rd_addr2;
  logic [7:0]   rd_grp;
  logic [127:0] rd_data1, rd_data2;
  logic         lu_e;
  logic [6:0]   lu_ocode;
  logic [127:0] lu_a, lu_b, lu_result;
  logic         wr_en, wr_ready;
  logic [4:0]   wr_addr;
  logic [7:0]   wr_grp;
  logic [3:0]   wr_lane_en;
  logic [127:0] wr_data;
  logic         busy, done;

  localparam logic [6:0] OC_VAND = 7'b0010010;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [7:0]   grp;
    logic [3:0]   lane;
    logic [127:0] data;
    logic [4:0]   addr;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  alu_logic_seq #(
    .DATA_WIDTH(32),
    .LANES     (4),
    .VL_WIDTH  (8),
    .REG_AW    (5)
  ) dut (
    .module_clk_i(clk),
    .rst_i       (rst),
    .op_valid_i  (op_valid),
    .op_ready_o  (op_ready),
    .op_ocode_i  (op_ocode),
    .op_vl_i     (op_vl),
    .op_vs1_i    (op_vs1),
    .op_vs2_i    (op_vs2),
    .op_vd_i     (op_vd),
    .rd_en_o     (rd_en),
    .rd_addr1_o  (rd_addr1),
    .rd_addr2_o  (rd_addr2),
    .rd_grp_o    (rd_grp),
    .rd_data1_i  (rd_data1),
    .rd_data2_i  (rd_data2),
    .lu_e_o      (lu_e),
    .lu_ocode_o  (lu_ocode),
    .lu_a_o      (lu_a),
    .lu_b_o      (lu_b),
    .lu_result_i (lu_result),
    .wr_en_o     (wr_en),
    .wr_ready_i  (wr_ready),
    .wr_addr_o   (wr_addr),
    .wr_grp_o    (wr_grp),
    .wr_lane_en_o(wr_lane_en),
    .wr_data_o   (wr_data),
    .busy_o      (busy),
    .done_o      (done)
  );

  function automatic logic [127:0] vrf(input logic [4:0] r, input logic [7:0] g);
    logic [127:0] v;
    for (int i = 0; i < 4; i++)
      v[i*32 +: 32] = {8'(r * 3 + 1), g, 8'(i), 8'h5A ^ {3'b000, r}};
    return v;
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      rd_data1 <= vrf(rd_addr1, rd_grp);
      rd_data2 <= vrf(rd_addr2, rd_grp);
    end else begin
      rd_data1 <= {4{32'hDEADBEEF}};
      rd_data2 <= {4{32'hC0FFEE11}};
    end
  end

  assign lu_result = lu_a & lu_b;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int vl, input logic [4:0] s1, input logic [4:0] s2,
                          input logic [4:0] d);
    exp_t e;
    for (int g = 0; g < (vl + 3) / 4; g++) begin
      e.grp  = 8'(g);
      e.addr = d;
      e.data = vrf(s1, 8'(g)) & vrf(s2, 8'(g));
      for (int i = 0; i < 4; i++) e.lane[i] = (g * 4 + i) < vl;
      sb.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && wr_en && wr_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_write", 128'(wr_grp), 128'hFFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("wr_grp", 128'(wr_grp), 128'(e.grp));
        chk("wr_lane_en", 128'(wr_lane_en), 128'(e.lane));
        chk("wr_data", wr_data, e.data);
        chk("wr_addr", 128'(wr_addr), 128'(e.addr));
      end
    end
  end

  task automatic issue(input int vl, input logic [4:0] s1, input logic [4:0] s2,
                       input logic [4:0] d);
    int w;
    op_ocode = OC_VAND;
    op_vl    = 8'(vl);
    op_vs1   = s1;
    op_vs2   = s2;
    op_vd    = d;
    op_valid = 1'b1;
    push_exp(vl, s1, s2, d);
    w = 0;
    forever begin
      @(negedge clk);
      if (op_ready) break;
      w++;
      if (w > 40) begin
        chk("accept_timeout", 128'(w), 128'(0));
        break;
      end
    end
    @(posedge clk);
    #1 op_valid = 1'b0;
  endtask

  // Called just after the accept edge; bit c of each mask is cycle c.
  task automatic trace(input int n, input int bp_lo, input int bp_hi,
                       output logic [31:0] rd_m, output logic [31:0] wr_m,
                       output logic [31:0] done_m, output logic [31:0] rdy_m,
                       output logic [31:0] lue_m, output int idle_opnd,
                       output logic [6:0] oc2);
    rd_m = '0; wr_m = '0; done_m = '0; rdy_m = '0; lue_m = '0; idle_opnd = 0; oc2 = '0;
    for (int c = 1; c <= n; c++) begin
      wr_ready = !(c >= bp_lo && c <= bp_hi);
      @(negedge clk);
      rd_m[c]   = rd_en;
      wr_m[c]   = wr_en;
      done_m[c] = done;
      rdy_m[c]  = op_ready;
      lue_m[c]  = lu_e;
      if (!lu_e && (lu_a != '0 || lu_b != '0)) idle_opnd++;
      if (c == 2) oc2 = lu_ocode;
      @(posedge clk);
      #1;
    end
    wr_ready = 1'b1;
  endtask

  logic [31:0] rd_m, wr_m, done_m, rdy_m, lue_m;
  logic [6:0]  oc2;
  int          idle_opnd, acc, bad;

  initial begin
    rst = 1'b1; op_valid = 1'b0; wr_ready = 1'b1;
    op_ocode = '0; op_vl = '0; op_vs1 = '0; op_vs2 = '0; op_vd = '0;
    repeat (2) @(negedge clk);
    chk("rst_op_ready", 128'(op_ready), 128'(1));
    chk("rst_strobes", 128'({rd_en, lu_e, wr_en, busy, done}), 128'(0));
    chk("rst_addr", 128'({rd_addr1, rd_addr2, rd_grp, wr_addr, wr_grp}), 128'(0));
    chk("rst_data", lu_a | lu_b | wr_data | 128'({lu_ocode, wr_lane_en}), 128'(0));
    @(posedge clk); #1 rst = 1'b0;

    // vl=8: two full groups
    issue(8, 5'd3, 5'd7, 5'd9);
    trace(6, 0, -1, rd_m, wr_m, done_m, rdy_m, lue_m, idle_opnd, oc2);
    chk("vl8_rd_en", 128'(rd_m), 128'h6);
    chk("vl8_wr_en", 128'(wr_m), 128'h18);
    chk("vl8_done", 128'(done_m), 128'h20);
    chk("vl8_ready", 128'(rdy_m), 128'h60);
    chk("vl8_lu_e", 128'(lue_m), 128'hC);
    chk("vl8_ocode", 128'(oc2), 128'(OC_VAND));
    chk("vl8_idle_opnd", 128'(idle_opnd), 128'(0));
    chk("idle_ocode", 128'(lu_ocode), 128'(0));

    // vl=5: tail group has only lane 0
    issue(5, 5'd1, 5'd2, 5'd4);
    trace(6, 0, -1, rd_m, wr_m, done_m, rdy_m, lue_m, idle_opnd, oc2);
    chk("vl5_rd_en", 128'(rd_m), 128'h6);
    chk("vl5_wr_en", 128'(wr_m), 128'h18);
    chk("vl5_done", 128'(done_m), 128'h20);

    // vl=0: immediate completion
    issue(0, 5'd1, 5'd2, 5'd4);
    trace(3, 0, -1, rd_m, wr_m, done_m, rdy_m, lue_m, idle_opnd, oc2);
    chk("vl0_rd_wr", 128'({rd_m, wr_m}), 128'(0));
    chk("vl0_done", 128'(done_m), 128'h2);
    chk("vl0_ready", 128'(rdy_m), 128'hE);

    // vl=16 with write backpressure in cycles 3..7
    issue(16, 5'd10, 5'd21, 5'd30);
    trace(13, 3, 7, rd_m, wr_m, done_m, rdy_m, lue_m, idle_opnd, oc2);
    chk("bp_rd_en", 128'(rd_m), 128'h306);
    chk("bp_wr_en", 128'(wr_m), 128'hFF8);
    chk("bp_done", 128'(done_m), 128'h1000);
    chk("bp_lu_e", 128'(lue_m), 128'h60C);
    chk("bp_ready", 128'(rdy_m), 128'h3000);
    chk("bp_idle_opnd", 128'(idle_opnd), 128'(0));

    // Second op held valid while the first runs
    issue(8, 5'd2, 5'd6, 5'd11);
    op_vl = 8'd5; op_vs1 = 5'd12; op_vs2 = 5'd13; op_vd = 5'd14; op_valid = 1'b1;
    push_exp(5, 5'd12, 5'd13, 5'd14);
    acc = 0; done_m = '0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      done_m[c] = done;
      if (op_ready) acc = c;
      @(posedge clk);
      #1;
      if (acc != 0) begin
        op_valid = 1'b0;
        break;
      end
    end
    chk("held_accept_cycle", 128'(acc), 128'(5));
    chk("held_done", 128'(done_m), 128'h20);
    trace(6, 0, -1, rd_m, wr_m, done_m, rdy_m, lue_m, idle_opnd, oc2);
    chk("held_b_wr_en", 128'(wr_m), 128'h18);
    chk("held_b_done", 128'(done_m), 128'h20);

    // Reset asserted in cycle 2 of a vl=16 op
    issue(16, 5'd5, 5'd8, 5'd17);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort_strobes", 128'({rd_en, lu_e, wr_en, busy, done}), 128'(0));
    chk("abort_ready", 128'(op_ready), 128'(1));
    chk("abort_outs", lu_a | wr_data | 128'({lu_ocode, rd_grp, wr_addr}), 128'(0));
    @(posedge clk); #1 rst = 1'b0;
    chk("abort_pending", 128'(sb.size()), 128'(4));
    sb.delete();
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (wr_en || rd_en || busy || !op_ready) bad++;
    end
    chk("abort_quiet", 128'(bad), 128'(0));

    chk("sb_drained", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
